// File: rtl/rd_pix_unpack_buf_if.sv
// Beat-write and display-pixel signals of the display read buffer.
// master = beat/timing source, slave = rd_pix_unpack_buf.
interface rd_pix_unpack_buf_if #(
    parameter int DATA_WIDTH = 256,
    parameter int PIX_WIDTH  = 16
);
    logic                  vs_in;
    logic                  de_in;
    logic                  buf_wr_en;
    logic [DATA_WIDTH-1:0] buf_wr_data;
    logic                  buf_afull;
    logic [PIX_WIDTH-1:0]  pix_data;
    logic                  de_out;

    modport master (
        output vs_in, de_in, buf_wr_en, buf_wr_data,
        input  buf_afull, pix_data, de_out
    );

    modport slave (
        input  vs_in, de_in, buf_wr_en, buf_wr_data,
        output buf_afull, pix_data, de_out
    );
endinterface

// File: rtl/rd_pix_unpack_buf.sv
// Display read buffer: beat FIFO, MSB-first RGB565 unpack, frame-start realign.
// Define RD_PIX_UNDERFLOW_CNT_EN to build the saturating underflow event counter.
module rd_pix_unpack_buf #(
    parameter int DATA_WIDTH  = 256,
    parameter int PIX_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    rd_pix_unpack_buf_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow,
    output logic [15:0]                   underflow_cnt
);
    localparam int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(PIX_PER_WORD);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_AFULL = (AW+1)'(AFULL_LEVEL);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(PIX_PER_WORD - 1);

    logic [DATA_WIDTH-1:0]                 mem [FIFO_DEPTH];
    logic [AW-1:0]                         wr_ptr;
    logic [AW-1:0]                         rd_ptr;
    logic [PIX_PER_WORD-1:0][PIX_WIDTH-1:0] hold;
    logic                                  hold_valid;
    logic [IW-1:0]                         idx;
    logic                                  vs_d;

    logic flush;
    logic fifo_empty;
    logic fifo_full;
    logic wr_fire;
    logic last_pix;
    logic pop;
    logic udf_evt;

    assign flush      = bus.vs_in && !vs_d;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LVL_FULL);
    assign wr_fire    = bus.buf_wr_en && !fifo_full && !flush;
    assign last_pix   = (idx == IDX_LAST);
    // Pop either to fill an empty hold register or to chain the next beat after the last pixel.
    assign pop        = !flush && !fifo_empty && (!hold_valid || (bus.de_in && last_pix));
    assign udf_evt    = !flush && bus.de_in && !hold_valid;

    assign bus.buf_afull = (fifo_level >= LVL_AFULL);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= bus.buf_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            hold         <= '0;
            hold_valid   <= 1'b0;
            idx          <= '0;
            vs_d         <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            bus.pix_data <= '0;
            bus.de_out   <= 1'b0;
        end else begin
            vs_d         <= bus.vs_in;
            bus.de_out   <= bus.de_in;
            bus.pix_data <= '0;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                hold_valid <= 1'b0;
                idx        <= '0;
                overflow   <= 1'b0;
                underflow  <= 1'b0;
            end else begin
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (bus.buf_wr_en && fifo_full) begin
                    overflow <= 1'b1;
                end
                unique case ({wr_fire, pop})
                    2'b10:   fifo_level <= fifo_level + LVL_ONE;
                    2'b01:   fifo_level <= fifo_level - LVL_ONE;
                    default: ;
                endcase

                if (bus.de_in) begin
                    if (hold_valid) begin
                        // Packed element 0 is the LSB pixel, so idx is reversed for MSB-first order.
                        bus.pix_data <= hold[~idx];
                        idx          <= idx + IDX_ONE;
                        if (last_pix && fifo_empty) begin
                            hold_valid <= 1'b0;
                        end
                    end else begin
                        underflow <= 1'b1;
                    end
                end

                if (pop) begin
                    rd_ptr     <= rd_ptr + PTR_ONE;
                    hold       <= mem[rd_ptr];
                    hold_valid <= 1'b1;
                    idx        <= '0;
                end
            end
        end
    end

`ifdef RD_PIX_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_cnt <= '0;
        end else if (udf_evt && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`else
    assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_rd_pix_unpack_buf.sv
// Self-checking bench for rd_pix_unpack_buf: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_rd_pix_unpack_buf;
    localparam int DW    = 256;
    localparam int PW    = 16;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    localparam int PPW   = DW / PW;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        underflow;
    logic [15:0] underflow_cnt;

    rd_pix_unpack_buf_if #(.DATA_WIDTH(DW), .PIX_WIDTH(PW)) bus ();

    rd_pix_unpack_buf #(
        .DATA_WIDTH (DW),
        .PIX_WIDTH  (PW),
        .FIFO_DEPTH (DEPTH),
        .AFULL_LEVEL(AFULL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underflow    (underflow),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of whole beats plus a queue of pixels still to emit.
    logic [DW-1:0] m_q[$];
    logic [PW-1:0] m_pend[$];
    logic          m_vs_d;
    logic          m_ovf;
    logic          m_udf;
    int            m_cnt;
    logic [PW-1:0] m_pix;
    logic          m_de_out;

    typedef struct {
        logic        r;
        logic        vs;
        logic        de;
        logic        wr;
        logic [15:0] base;
        logic [15:0] pix;
        logic        de_out;
        int          level;
        logic        udf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic r, logic vs, logic de, logic wr, logic [15:0] base,
                                 logic [15:0] pix, logic deo, int level, logic udf);
        vec_t v;
        v.r = r; v.vs = vs; v.de = de; v.wr = wr; v.base = base;
        v.pix = pix; v.de_out = deo; v.level = level; v.udf = udf;
        return v;
    endfunction

    // Pixel k of the beat (k = 0 is the first pixel out, top bits) is base ^ k.
    function automatic logic [DW-1:0] mk_beat(logic [PW-1:0] base);
        logic [DW-1:0] b;
        b = '0;
        for (int k = 0; k < PPW; k++) begin
            b[DW-1-k*PW -: PW] = base ^ PW'(k);
        end
        return b;
    endfunction

    task automatic load_pend(logic [DW-1:0] b);
        for (int k = 0; k < PPW; k++) begin
            m_pend.push_back(b[DW-1-k*PW -: PW]);
        end
    endtask

    task automatic model_step();
        logic was_empty, was_full, had;
        if (rst) begin
            m_q.delete(); m_pend.delete();
            m_vs_d = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_cnt = 0;
            m_pix = '0; m_de_out = 1'b0;
        end else begin
            m_de_out = bus.de_in;
            m_pix    = '0;
            if (bus.vs_in && !m_vs_d) begin
                m_q.delete(); m_pend.delete();
                m_ovf = 1'b0; m_udf = 1'b0;
            end else begin
                was_empty = (m_q.size() == 0);
                was_full  = (m_q.size() == DEPTH);
                had       = (m_pend.size() != 0);
                if (bus.de_in) begin
                    if (had) begin
                        m_pix = m_pend.pop_front();
                        if (m_pend.size() == 0 && !was_empty) load_pend(m_q.pop_front());
                    end else begin
                        m_udf = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                end
                if (!had && !was_empty) load_pend(m_q.pop_front());
                if (bus.buf_wr_en) begin
                    if (was_full) m_ovf = 1'b1;
                    else m_q.push_back(bus.buf_wr_data);
                end
            end
            m_vs_d = bus.vs_in;
        end
    endtask

    function automatic int exp_cnt();
`ifdef RD_PIX_UNDERFLOW_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_model();
        chk("model_pix_data", 32'(bus.pix_data), 32'(m_pix));
        chk("model_de_out", 32'(bus.de_out), 32'(m_de_out));
        chk("model_fifo_level", 32'(fifo_level), 32'(m_q.size()));
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
        chk("model_underflow", 32'(underflow), 32'(m_udf));
        chk("model_buf_afull", 32'(bus.buf_afull), 32'(m_q.size() >= AFULL));
        chk("model_underflow_cnt", 32'(underflow_cnt), 32'(exp_cnt()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic set_in(logic vs, logic de, logic wr, logic [DW-1:0] data);
        bus.vs_in = vs; bus.de_in = de; bus.buf_wr_en = wr; bus.buf_wr_data = data;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_beat(logic [15:0] base);
        set_in(1'b0, 1'b0, 1'b1, mk_beat(base));
        tick();
        set_in(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(int n);
        set_in(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic vs_r;

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, '0);

        // Vector table: r vs de wr base | pix de_out level underflow
        vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 16'h0000, 1'b0, 1, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hA000, 1'b1, 0, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hA001, 1'b1, 0, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b1, 16'hB000, 16'hA002, 1'b1, 1, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 16'hB000, 16'h0000, 1'b0, 1, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hB000, 1'b1, 0, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r;
            set_in(vecs[i].vs, vecs[i].de, vecs[i].wr, mk_beat(vecs[i].base));
            tick();
            chk($sformatf("vec%0d_pix", i), 32'(bus.pix_data), 32'(vecs[i].pix));
            chk($sformatf("vec%0d_de_out", i), 32'(bus.de_out), 32'(vecs[i].de_out));
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].level));
            chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].udf));
        end

        // Basic unpack: pixel k = 15-k
        do_reset();
        write_beat(16'h000F);
        idle(2);
        for (int i = 0; i < PPW; i++) begin
            set_in(1'b0, 1'b1, 1'b0, '0);
            tick();
            chk("basic_pix", 32'(bus.pix_data), 32'(15 - i));
            chk("basic_de_out", 32'(bus.de_out), 32'd1);
        end
        idle(1);
        chk("basic_no_underflow", 32'(underflow), 32'd0);

        // Seamless beats
        do_reset();
        for (int b = 1; b <= 3; b++) write_beat(16'(b << 12));
        idle(2);
        for (int i = 0; i < 3 * PPW; i++) begin
            set_in(1'b0, 1'b1, 1'b0, '0);
            tick();
            chk("seam_pix", 32'(bus.pix_data), 32'((((i / PPW) + 1) << 12) ^ (i % PPW)));
        end
        idle(1);
        chk("seam_level", 32'(fifo_level), 32'd0);
        chk("seam_underflow", 32'(underflow), 32'd0);

        // Full / overflow: one beat goes to the hold register, 16 fill the FIFO, the 18th drops
        do_reset();
        for (int k = 0; k < 18; k++) begin
            write_beat(16'(k << 8));
            chk("ovf_afull", 32'(bus.buf_afull), 32'(k >= AFULL));
        end
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 17 * PPW; i++) begin
            set_in(1'b0, 1'b1, 1'b0, '0);
            tick();
            chk("ovf_readout_pix", 32'(bus.pix_data), 32'(((i / PPW) << 8) ^ (i % PPW)));
        end
        set_in(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("ovf_dropped_beat_absent", 32'(underflow), 32'd1);

        // Underflow
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 1'b0, '0);
            tick();
            chk("udf_pix", 32'(bus.pix_data), 32'd0);
        end
        idle(1);
        chk("udf_flag", 32'(underflow), 32'd1);
`ifdef RD_PIX_UNDERFLOW_CNT_EN
        chk("udf_cnt", 32'(underflow_cnt), 32'd4);
`else
        chk("udf_cnt", 32'(underflow_cnt), 32'd0);
`endif

        // Frame flush mid-beat with simultaneous write
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, '0);
        tick();
        for (int k = 0; k < 5; k++) write_beat(16'(16'h4000 | (k << 8)));
        idle(2);
        for (int i = 0; i < 7; i++) begin
            set_in(1'b0, 1'b1, 1'b0, '0);
            tick();
        end
        chk("flush_pre_pix", 32'(bus.pix_data), 32'h4006);
        set_in(1'b1, 1'b1, 1'b1, mk_beat(16'hEE00));
        tick();
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_underflow", 32'(underflow), 32'd0);
        chk("flush_overflow", 32'(overflow), 32'd0);
        chk("flush_de_out", 32'(bus.de_out), 32'd1);
        chk("flush_pix", 32'(bus.pix_data), 32'd0);
        idle(1);
        chk("flush_beat_discarded", 32'(fifo_level), 32'd0);
        write_beat(16'h7700);
        idle(2);
        set_in(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("flush_realign_pix", 32'(bus.pix_data), 32'h7700);

        // Reset during active readout
        do_reset();
        write_beat(16'h1100);
        write_beat(16'h2200);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 1'b0, '0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_pix", 32'(bus.pix_data), 32'd0);
        chk("rst_de_out", 32'(bus.de_out), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_afull", 32'(bus.buf_afull), 32'd0);
        chk("rst_cnt", 32'(underflow_cnt), 32'd0);

        // Randomized traffic, alternating write-heavy and read-heavy phases
        vs_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int wr_pct;
            wr_pct = ((c / 400) % 2 == 0) ? 85 : 25;
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 149) == 0) vs_r = ~vs_r;
            set_in(vs_r, ($urandom_range(0, 99) < 60),
                   ($urandom_range(0, 99) < wr_pct),
                   {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom});
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
